// File: rtl/restoring_div_n.sv
// restoring_div_n: iterative restoring divider, one quotient bit per clock,
// divide-by-zero early-out; signed mode compiled in with `DIV_SIGNED_EN.
// Ports: clk, n_rst (async, active-low), start, signed_op, src1, src2 in;
//        qut, rmd (registered results), busy, done (pulse), dbz out.
module restoring_div_n #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic [WIDTH-1:0] qut,
  output logic [WIDTH-1:0] rmd,
  output logic             busy,
  output logic             done,
  output logic             dbz
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [CW-1:0]    cnt;
  logic             dbz_p;

  logic [WIDTH:0]   acc_sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  // acc < dvs always holds, so the shifted value fits WIDTH+1 bits and
  // the MSB of the difference is a clean borrow flag.
  assign acc_sh = {acc, quo[WIDTH-1]};
  assign trial  = acc_sh - {1'b0, dvs};

`ifdef DIV_SIGNED_EN
  logic a_neg;
  logic b_neg;
  logic neg_q;
  logic neg_r;

  assign a_neg = signed_op & src1[WIDTH-1];
  assign b_neg = signed_op & src2[WIDTH-1];
  assign a_mag = a_neg ? -src1 : src1;
  assign b_mag = b_neg ? -src2 : src2;
  assign q_fix = neg_q ? -quo : quo;
  assign r_fix = neg_r ? -acc : acc;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == IDLE && start) begin
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
    end
  end
`else
  logic unused_signed;

  assign unused_signed = signed_op;
  assign a_mag = src1;
  assign b_mag = src2;
  assign q_fix = quo;
  assign r_fix = acc;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      acc   <= '0;
      quo   <= '0;
      dvs   <= '0;
      cnt   <= '0;
      dbz_p <= 1'b0;
      qut   <= '0;
      rmd   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      dbz   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            dvs  <= b_mag;
            cnt  <= CW'(WIDTH - 1);
            quo  <= a_mag;
            if (src2 == '0) begin
              // raw dividend parked in acc, returned untouched as rmd
              acc   <= src1;
              dbz_p <= 1'b1;
              state <= FIX;
            end else begin
              acc   <= '0;
              dbz_p <= 1'b0;
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (trial[WIDTH]) begin
            acc <= acc_sh[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end else begin
            acc <= trial[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end
          cnt <= cnt - CW'(1);
          if (cnt == '0) begin
            state <= FIX;
          end
        end
        FIX: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
          if (dbz_p) begin
            qut <= '1;
            rmd <= acc;
            dbz <= 1'b1;
          end else begin
            qut <= q_fix;
            rmd <= r_fix;
            dbz <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/restoring_div_n.md
# restoring_div_n

Parametrised multi-cycle restoring divider: the successor to the fixed 32-bit divider in the arithmetic library. It computes quotient and remainder of WIDTH-bit operands, one quotient bit per clock, with divide-by-zero early-out and optional signed mode. It sits beside the adder and multiplier units as a shared iterative execution unit driven by a start/done handshake.

## Interface
- WIDTH, 32, operand/result width in bits; legal range 4..64
- clk  in  1  clock, all state updates on rising edge
- n_rst  in  1  reset, asynchronous and active-low
- start  in  1  request; sampled only when busy=0
- signed_op  in  1  1 = signed (two's complement) division; ignored when signed support is compiled out
- src1  in  WIDTH  dividend, sampled with start
- src2  in  WIDTH  divisor, sampled with start
- qut  out  WIDTH  quotient, registered, valid from done until next done
- rmd  out  WIDTH  remainder, registered, same validity as qut
- busy  out  1  high from the edge accepting start until the edge that asserts done
- done  out  1  one-cycle pulse, results valid
- dbz  out  1  divide-by-zero flag, registered with qut/rmd

## Operation
- FSM states: IDLE, CALC, FIX.
- IDLE: start=1 at an edge -> latch operands, clear accumulator, load iteration counter with WIDTH-1; go to CALC, or to FIX directly if src2==0.
- Signed request: operands converted to magnitudes on capture; sign of quotient = sign(src1) XOR sign(src2); sign of remainder = sign(src1).
- CALC: each edge, {acc,q} shifted left by 1; trial = acc_shifted - divisor (WIDTH+1 bits); trial negative -> keep shifted acc, quotient LSB=0; else acc=trial, LSB=1. Counter decrements; when counter==0 at an edge, go to FIX.
- FIX: apply sign correction (two's-complement negate where required), register qut/rmd/dbz, pulse done, return to IDLE.
- Divide by zero: qut = all ones, rmd = src1 unmodified (signed or unsigned), dbz=1.
- Signed overflow (src1 = most-negative, src2 = -1): qut = most-negative, rmd = 0, dbz=0; falls out of magnitude arithmetic without special casing.
- start while busy=1: ignored, no effect on operation in progress or on captured operands.
- start on the same edge that asserts done: ignored (busy still 1 at that edge); a new request is accepted at the earliest on the following edge.
- qut/rmd/dbz hold their values between done pulses; they change only on the FIX edge.

## Timing
- Reset values: qut=0, rmd=0, busy=0, done=0, dbz=0, FSM=IDLE.
- Normal latency: start accepted at edge T0 -> CALC edges T1..T(WIDTH) -> FIX edge T(WIDTH+1); done high for the cycle after T(WIDTH+1). WIDTH=32: 33 cycles.
- Divide by zero: T0 -> FIX edge T1; done high for the cycle after T1 (latency 1).
- busy is 1 during CALC and FIX and drops on the edge that raises done; done and busy are never 1 simultaneously.
- Reset asserted mid-operation: immediately returns to reset values; no done pulse is emitted for the aborted request.
- Throughput: one division per WIDTH+2 cycles with back-to-back start.

## Configuration
- DIV_SIGNED_EN defined: signed_op honoured; operand-magnitude and result-negate logic present.
- DIV_SIGNED_EN undefined: all operations unsigned, signed_op ignored, negate logic removed; latency unchanged (FIX state retained to register results).

## Test plan
- WIDTH=32, unsigned 100/7 -> qut=14, rmd=2, dbz=0, done exactly 33 cycles after start edge, busy high 33 cycles.
- WIDTH=32, src2=0, src1=0x1234 -> done 1 cycle after start, qut=0xFFFFFFFF, rmd=0x1234, dbz=1.
- DIV_SIGNED_EN, WIDTH=32, signed -7/2 -> qut=-3 (0xFFFFFFFD), rmd=-1; 0x80000000/-1 -> qut=0x80000000, rmd=0.
- WIDTH=8, unsigned 255/16 -> qut=15, rmd=15, done 9 cycles after start; exhaustive 8-bit sweep against reference model.
- start pulsed every cycle while busy and on the done cycle -> only first request processed; next accepted on edge after done.
- n_rst asserted at cycle 10 of a 32-bit division -> all outputs 0, no done; fresh start afterwards completes correctly.
